// File: rtl/tick_counter_if.sv
// Handshake bundle for tick_counter: control inputs in, count/status out.
interface tick_counter_if #(
  parameter int COUNT_WIDTH = 4
);

  logic                   div_in;
  logic                   start;
  logic                   stop;
  logic                   clear;
  logic                   dir;
  logic [COUNT_WIDTH-1:0] count;
  logic                   tick;
  logic                   wrap;
  logic                   running;

  // Driver side: produces the control inputs, observes the counter.
  modport master (
    output div_in,
    output start,
    output stop,
    output clear,
    output dir,
    input  count,
    input  tick,
    input  wrap,
    input  running
  );

  // Counter side.
  modport slave (
    input  div_in,
    input  start,
    input  stop,
    input  clear,
    input  dir,
    output count,
    output tick,
    output wrap,
    output running
  );

endinterface

// File: rtl/tick_counter.sv
// Counts rising edges of an asynchronous divider output while in RUN.
// Up/down modulo-(MAX_VALUE+1) counter with one-cycle tick and wrap pulses.
module tick_counter #(
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned MAX_VALUE   = 9
) (
  input logic           clk,
  input logic           rst,
  tick_counter_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] MaxCount = COUNT_WIDTH'(MAX_VALUE);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic                   s1_q, s2_q, prev_q;
  logic                   rise;
  logic                   count_en;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   wrap_q, wrap_d;
  logic                   tick_q;
  logic                   running;

  // Two-flop synchronizer for div_in plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= bus.div_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Rising edge of the synchronized divider; falling edges are ignored.
  assign rise = s2_q & ~prev_q;

  // Tick pulse register, active in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= rise;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stop wins over a coincident start; clear never moves state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (bus.start && !bus.stop) state_d = StRun;
      StRun:  if (bus.stop)               state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: running is a pure decode of the state register.
  always_comb begin
    running = (state_q == StRun);
  end

  // Count next state. Only the pre-edge state gates counting, so a start
  // coincident with an edge misses it and a coincident stop still counts it.
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    count_en = (state_q == StRun) && rise;
    if (bus.clear) begin
      count_d = '0;
    end else if (count_en) begin
      if (!bus.dir) begin
        // >= keeps the count in range even if it were ever corrupted.
        if (count_q >= MaxCount) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0 || count_q > MaxCount) begin
          count_d = MaxCount;
          wrap_d  = (count_q == '0);
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // Count and wrap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = running;

endmodule

// File: tb/tb_tick_counter.sv
// Self-checking bench for tick_counter: vector table, directed corner
// sequences and randomized stimulus against a sample-history reference model.
module tb_tick_counter;

  localparam int CW   = 4;
  localparam int MAXV = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tick_counter_if #(.COUNT_WIDTH(CW)) bus ();

  tick_counter #(
    .COUNT_WIDTH(CW),
    .MAX_VALUE  (MAXV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a tick is seen at edge n when div_in was sampled high at
  // edge n-2 and low at edge n-3. Count is plain modulo arithmetic.
  int m_cnt;
  bit m_run, m_tick, m_wrap;
  bit m_hist[$];

  function automatic void model_reset();
    m_cnt  = 0;
    m_run  = 1'b0;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    m_hist = '{1'b0, 1'b0, 1'b0};
  endfunction

  function automatic void model_step(bit d, bit st, bit sp, bit cl, bit dr);
    bit ev;
    int old;
    ev     = m_hist[$-1] && !m_hist[$-2];
    old    = m_cnt;
    m_tick = ev;
    m_wrap = 1'b0;
    if (cl) begin
      m_cnt = 0;
    end else if (m_run && ev) begin
      if (!dr) begin
        m_cnt  = (old + 1) % (MAXV + 1);
        m_wrap = (old == MAXV);
      end else begin
        m_cnt  = (old + MAXV) % (MAXV + 1);
        m_wrap = (old == 0);
      end
    end
    m_run = m_run ? !sp : (st && !sp);
    m_hist.push_back(d);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
  endfunction

  // One clock: drive after negedge, advance model at posedge, check at negedge.
  task automatic cycle(input bit d, input bit st, input bit sp, input bit cl, input bit dr);
    bus.div_in = d;
    bus.start  = st;
    bus.stop   = sp;
    bus.clear  = cl;
    bus.dir    = dr;
    @(posedge clk);
    model_step(d, st, sp, cl, dr);
    @(negedge clk);
    chk("model_count", bus.count, m_cnt);
    chk("model_tick", bus.tick, m_tick);
    chk("model_wrap", bus.wrap, m_wrap);
    chk("model_running", bus.running, m_run);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
  endtask

  // One div_in rising edge; st/sp/cl land in the cycle whose edge counts it.
  task automatic tick_pulse(input bit st, input bit sp, input bit cl, input bit dr,
                            output logic [CW-1:0] c, output logic w, output logic r);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, dr);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, dr);
    cycle(1'b0, st, sp, cl, dr);
    c = bus.count;
    w = bus.wrap;
    r = bus.running;
    chk("pulse_tick", bus.tick, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, dr);
  endtask

  typedef struct {
    bit d, st, sp, cl, dr;
    int cnt;
    bit tk, wr, rn;
  } vec_t;

  initial begin
    vec_t          tbl[14];
    int            exp_up[12];
    int            exp_dn[3];
    logic [CW-1:0] c;
    logic          w, r;
    int            ntick, tick_at;
    bit            d, dr, st, sp, cl;

    //          d  st sp cl dr  cnt tk wr rn
    tbl[0]  = '{0, 1, 0, 0, 0,  0,  0, 0, 1};
    tbl[1]  = '{1, 0, 0, 0, 0,  0,  0, 0, 1};
    tbl[2]  = '{1, 0, 0, 0, 0,  0,  0, 0, 1};
    tbl[3]  = '{1, 0, 0, 0, 0,  1,  1, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0,  1,  0, 0, 1};
    tbl[5]  = '{0, 0, 0, 1, 0,  0,  0, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 1,  0,  0, 0, 1};
    tbl[7]  = '{1, 0, 0, 0, 1,  0,  0, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 1,  9,  1, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 1,  9,  0, 0, 1};
    tbl[10] = '{0, 1, 1, 0, 1,  9,  0, 0, 0};
    tbl[11] = '{0, 1, 1, 0, 1,  9,  0, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 1,  9,  0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 1,  9,  0, 0, 1};
    exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    exp_dn = '{9, 8, 7};

    bus.div_in = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.clear  = 1'b0;
    bus.dir    = 1'b0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_running", bus.running, 0);
    rst = 1'b0;
    model_reset();

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].d, tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].dr);
      chk($sformatf("tbl%0d_count", i), bus.count, tbl[i].cnt);
      chk($sformatf("tbl%0d_tick", i), bus.tick, tbl[i].tk);
      chk($sformatf("tbl%0d_wrap", i), bus.wrap, tbl[i].wr);
      chk($sformatf("tbl%0d_running", i), bus.running, tbl[i].rn);
    end

    // Tick latency and a long high level giving a single tick.
    ntick   = 0;
    tick_at = -1;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.tick) begin
        ntick++;
        if (tick_at < 0) tick_at = i;
      end
    end
    chk("latency_ticks", ntick, 1);
    chk("latency_edge", tick_at, 2);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Up wrap through MAX_VALUE.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick_pulse(1'b0, 1'b0, 1'b0, 1'b0, c, w, r);
      chk($sformatf("up%0d_count", i), c, exp_up[i]);
      chk($sformatf("up%0d_wrap", i), w, (i == 9) ? 1 : 0);
    end

    // Down wrap through zero.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick_pulse(1'b0, 1'b0, 1'b0, 1'b1, c, w, r);
      chk($sformatf("dn%0d_count", i), c, exp_dn[i]);
      chk($sformatf("dn%0d_wrap", i), w, (i == 0) ? 1 : 0);
    end

    // Stop coincident with a tick at count 4 still counts it.
    repeat (3) tick_pulse(1'b0, 1'b0, 1'b0, 1'b1, c, w, r);
    chk("pre_stop_count", c, 4);
    tick_pulse(1'b0, 1'b1, 1'b0, 1'b0, c, w, r);
    chk("stop_tick_count", c, 5);
    chk("stop_tick_running", r, 0);

    // Clear coincident with a wrapping tick at count 9.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick_pulse(1'b0, 1'b0, 1'b0, 1'b0, c, w, r);
    chk("pre_clear_count", c, 9);
    tick_pulse(1'b0, 1'b0, 1'b1, 1'b0, c, w, r);
    chk("clear_tick_count", c, 0);
    chk("clear_tick_wrap", w, 0);

    // Start/stop together from IDLE, then start coincident with a tick.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_stop_running", bus.running, 0);
    tick_pulse(1'b1, 1'b0, 1'b0, 1'b0, c, w, r);
    chk("start_tick_count", c, 0);
    chk("start_tick_running", r, 1);
    tick_pulse(1'b0, 1'b0, 1'b0, 1'b0, c, w, r);
    chk("first_counted", c, 1);

    // Asynchronous reset mid-RUN at count 6.
    repeat (5) tick_pulse(1'b0, 1'b0, 1'b0, 1'b0, c, w, r);
    chk("pre_rst_count", c, 6);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_running", bus.running, 0);
    chk("arst_tick", bus.tick, 0);
    chk("arst_wrap", bus.wrap, 0);
    #1 rst = 1'b0;
    model_reset();
    repeat (2) begin
      tick_pulse(1'b0, 1'b0, 1'b0, 1'b0, c, w, r);
      chk("post_rst_count", c, 0);
      chk("post_rst_running", r, 0);
    end

    // Randomized stimulus against the model.
    d  = 1'b0;
    dr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) d = ~d;
      if ($urandom_range(15) == 0) dr = ~dr;
      st = ($urandom_range(7) == 0);
      sp = ($urandom_range(15) == 0);
      cl = ($urandom_range(31) == 0);
      cycle(d, st, sp, cl, dr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
